// File: rtl/cool_isa_pkg.sv
// Shared instruction-set definitions for the encode and decode sides:
// field widths, bit positions within the 16-bit word, the illegal-opcode
// threshold, and helpers to pack a word and classify an opcode.
package cool_isa_pkg;

   localparam int INST_W    = 16;
   localparam int COND_W    = 2;
   localparam int OP_W      = 4;
   localparam int REG_W     = 3;

   // Field LSB positions inside the packed word
   localparam int COND_LSB  = 14;
   localparam int OP_LSB    = 10;
   localparam int DEST_LSB  = 7;
   localparam int SRC1_LSB  = 4;
   localparam int SRC2_LSB  = 1;
   localparam int SHIFT_BIT = 0;

   // Opcodes at or above this value are reserved
   localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'hC;

   function automatic logic [INST_W-1:0] pack_inst(
      input logic [COND_W-1:0] cond,
      input logic [OP_W-1:0]   op_code,
      input logic [REG_W-1:0]  dest_reg,
      input logic [REG_W-1:0]  src_reg_1,
      input logic [REG_W-1:0]  src_reg_2,
      input logic              shift
   );
      logic [INST_W-1:0] w;
      w                      = '0;
      w[COND_LSB +: COND_W]  = cond;
      w[OP_LSB +: OP_W]      = op_code;
      w[DEST_LSB +: REG_W]   = dest_reg;
      w[SRC1_LSB +: REG_W]   = src_reg_1;
      w[SRC2_LSB +: REG_W]   = src_reg_2;
      w[SHIFT_BIT]           = shift;
      return w;
   endfunction

   function automatic logic op_is_illegal(input logic [OP_W-1:0] op_code);
      return (op_code >= OP_ILLEGAL_MIN);
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// Circular buffer of instruction words. Pointers wrap modulo DEPTH; the
// head word is presented registered (zero when empty), so there is no
// fall-through from write to read. flush clears pointers and count.
module inst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [4:0]       count,
   output logic             full,
   output logic             empty
);

   localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0]      DEPTH_C  = 5'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]       count_q, count_d;
   logic             push, pop, mem_we;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == 5'd0);
   assign count   = count_q;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // Next pointer/count state; flush overrides any push or pop
   always_comb begin
      push     = wr_en && !full;
      pop      = rd_en && !empty;
      mem_we   = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = 5'd0;
      end else begin
         mem_we = push;
         if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 5'd1;
         end else if (pop && !push) begin
            count_d = count_q - 5'd1;
         end
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 5'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/inst_encoder.sv
// Packs instruction fields into a 16-bit word and queues it in inst_fifo.
// Build option INST_ENCODER_OPCHECK_EN: opcodes 4'hC..4'hF are accepted on
// the handshake but dropped, and a sticky err flag is raised until rst or
// flush. Without it every opcode is written and err is tied low.
module inst_encoder
   import cool_isa_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [COND_W-1:0] cond,
   input  logic [OP_W-1:0]   op_code,
   input  logic [REG_W-1:0]  dest_reg,
   input  logic [REG_W-1:0]  src_reg_1,
   input  logic [REG_W-1:0]  src_reg_2,
   input  logic              shift,
   input  logic              flush,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [4:0]        count,
   output logic              err
);

   logic [INST_W-1:0] word;
   logic              accept;
   logic              fifo_wr;
   logic              fifo_full;
   logic              fifo_empty;

   assign in_ready   = !fifo_full;
   assign inst_valid = !fifo_empty;

`ifdef INST_ENCODER_OPCHECK_EN
   logic err_q, err_d;
   logic illegal;

   // Pack fields, gate reserved opcodes out of the buffer, track sticky err
   always_comb begin
      word    = pack_inst(cond, op_code, dest_reg, src_reg_1, src_reg_2, shift);
      accept  = in_valid && in_ready;
      illegal = op_is_illegal(op_code);
      fifo_wr = accept && !illegal;
      err_d   = err_q;
      if (flush) begin
         err_d = 1'b0;
      end else if (accept && illegal) begin
         err_d = 1'b1;
      end
   end

   // Sticky error register
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   // Pack fields; every accepted tuple is written
   always_comb begin
      word    = pack_inst(cond, op_code, dest_reg, src_reg_1, src_reg_2, shift);
      accept  = in_valid && in_ready;
      fifo_wr = accept;
   end

   assign err = 1'b0;
`endif

   inst_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INST_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .wr_en   (fifo_wr),
      .wr_data (word),
      .rd_en   (inst_valid && inst_ready),
      .rd_data (inst),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (DEPTH=4). Expected words are hand-packed.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, shift, flush, inst_valid, inst_ready, err;
   logic [1:0]  cond;
   logic [3:0]  op_code;
   logic [2:0]  dest_reg, src_reg_1, src_reg_2;
   logic [15:0] inst;
   logic [4:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   inst_encoder #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cond       (cond),
      .op_code    (op_code),
      .dest_reg   (dest_reg),
      .src_reg_1  (src_reg_1),
      .src_reg_2  (src_reg_2),
      .shift      (shift),
      .flush      (flush),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .count      (count),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fields(input logic [1:0] c, input logic [3:0] o, input logic [2:0] d,
                         input logic [2:0] s1, input logic [2:0] s2, input logic sh);
      cond = c; op_code = o; dest_reg = d; src_reg_1 = s1; src_reg_2 = s2; shift = sh;
   endtask

   // Hand-packed words
   localparam logic [15:0] W_A = 16'h04A6; // 0,1,1,2,3,0
   localparam logic [15:0] W_B = 16'h4939; // 1,2,2,3,4,1
   localparam logic [15:0] W_C = 16'hEF8A; // 3,B,7,0,5,0
   localparam logic [15:0] W_D = 16'hA1E3; // 2,8,3,6,1,1
   localparam logic [15:0] W_X = 16'h3493; // 0,D,1,1,1,1

   initial begin
      rst = 1'b1; in_valid = 1'b0; inst_ready = 1'b0; flush = 1'b0;
      fields(2'd0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0);
      step(); step();
      rst = 1'b0;
      chk("rst_count", 16'(count), 16'd0);
      chk("rst_inst_valid", 16'(inst_valid), 16'd0);
      chk("rst_inst", inst, 16'h0000);
      chk("rst_in_ready", 16'(in_ready), 16'd1);
      chk("rst_err", 16'(err), 16'd0);

      // Basic packing and one-cycle latency
      fields(2'b10, 4'h3, 3'd5, 3'd2, 3'd7, 1'b1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("pack_inst", inst, 16'h8EAF);
      chk("pack_valid", 16'(inst_valid), 16'd1);
      chk("pack_count", 16'(count), 16'd1);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("pop_count", 16'(count), 16'd0);
      chk("pop_valid", 16'(inst_valid), 16'd0);
      chk("empty_inst", inst, 16'h0000);

      // Fill to DEPTH with downstream stalled
      in_valid = 1'b1;
      fields(2'd0, 4'h1, 3'd1, 3'd2, 3'd3, 1'b0); step(); chk("fill1_count", 16'(count), 16'd1);
      fields(2'd1, 4'h2, 3'd2, 3'd3, 3'd4, 1'b1); step(); chk("fill2_count", 16'(count), 16'd2);
      fields(2'd3, 4'hB, 3'd7, 3'd0, 3'd5, 1'b0); step(); chk("fill3_count", 16'(count), 16'd3);
      chk("fill3_in_ready", 16'(in_ready), 16'd1);
      fields(2'd2, 4'h8, 3'd3, 3'd6, 3'd1, 1'b1); step(); chk("fill4_count", 16'(count), 16'd4);
      chk("full_in_ready", 16'(in_ready), 16'd0);
      // Fifth tuple offered while full: ignored
      fields(2'd1, 4'h4, 3'd0, 3'd0, 3'd0, 1'b0);
      step();
      chk("full_ignore_count", 16'(count), 16'd4);
      chk("head_A", inst, W_A);
      // Full with in_valid and inst_ready: pop only
      inst_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("full_pop_count", 16'(count), 16'd3);
      chk("full_pop_in_ready", 16'(in_ready), 16'd1);
      chk("head_B", inst, W_B);
      step(); chk("head_C", inst, W_C); chk("drain_count2", 16'(count), 16'd2);
      step(); chk("head_D", inst, W_D); chk("drain_count1", 16'(count), 16'd1);
      step(); chk("drain_empty", 16'(inst_valid), 16'd0); chk("drain_inst", inst, 16'h0000);
      inst_ready = 1'b0;

      // Simultaneous push and pop at count=1
      in_valid = 1'b1;
      fields(2'd0, 4'h1, 3'd1, 3'd2, 3'd3, 1'b0); step();
      inst_ready = 1'b1;
      fields(2'd1, 4'h2, 3'd2, 3'd3, 3'd4, 1'b1); step();
      chk("pushpop_count", 16'(count), 16'd1);
      chk("pushpop_head", inst, W_B);
      inst_ready = 1'b0;
      fields(2'd3, 4'hB, 3'd7, 3'd0, 3'd5, 1'b0); step();
      chk("preflush_count", 16'(count), 16'd2);
      // Flush beats push and pop
      inst_ready = 1'b1; flush = 1'b1;
      fields(2'd2, 4'h8, 3'd3, 3'd6, 3'd1, 1'b1); step();
      flush = 1'b0; in_valid = 1'b0; inst_ready = 1'b0;
      chk("flush_count", 16'(count), 16'd0);
      chk("flush_valid", 16'(inst_valid), 16'd0);
      chk("flush_inst", inst, 16'h0000);
      chk("flush_in_ready", 16'(in_ready), 16'd1);

      // Reserved opcode
      fields(2'd0, 4'hD, 3'd1, 3'd1, 3'd1, 1'b1);
      in_valid = 1'b1;
      chk("illegal_in_ready", 16'(in_ready), 16'd1);
      step();
      in_valid = 1'b0;
`ifdef INST_ENCODER_OPCHECK_EN
      chk("illegal_count", 16'(count), 16'd0);
      chk("illegal_err", 16'(err), 16'd1);
      step();
      chk("illegal_err_hold", 16'(err), 16'd1);
`else
      chk("opD_count", 16'(count), 16'd1);
      chk("opD_inst", inst, W_X);
      chk("opD_err", 16'(err), 16'd0);
`endif
      flush = 1'b1; step(); flush = 1'b0;
      chk("flush_err", 16'(err), 16'd0);
      chk("flush2_count", 16'(count), 16'd0);

      // Reset mid-stream at count=3, with a push pending during reset
      in_valid = 1'b1;
      fields(2'd0, 4'h1, 3'd1, 3'd2, 3'd3, 1'b0); step();
      fields(2'd1, 4'h2, 3'd2, 3'd3, 3'd4, 1'b1); step();
      fields(2'd3, 4'hB, 3'd7, 3'd0, 3'd5, 1'b0); step();
      chk("prerst_count", 16'(count), 16'd3);
      rst = 1'b1;
      fields(2'd2, 4'h8, 3'd3, 3'd6, 3'd1, 1'b1);
      step();
      rst = 1'b0;
      chk("midrst_count", 16'(count), 16'd0);
      chk("midrst_valid", 16'(inst_valid), 16'd0);
      chk("midrst_inst", inst, 16'h0000);
      chk("midrst_in_ready", 16'(in_ready), 16'd1);
      chk("midrst_err", 16'(err), 16'd0);
      step();
      in_valid = 1'b0;
      chk("postrst_inst", inst, W_D);
      chk("postrst_count", 16'(count), 16'd1);
      chk("postrst_valid", 16'(inst_valid), 16'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
